// File: rtl/edsac_mem_pkg.sv
// Shared constants and FSM state type for the EDSAC mercury-store tank sequencers.
package edsac_mem_pkg;

    localparam int unsigned DIGITS_PER_MINOR = 18;
    localparam int unsigned MINORS_PER_TANK  = 32;
    localparam int unsigned SHORT_W          = 17;
    localparam int unsigned LONG_W           = 35;

    typedef enum logic [1:0] {
        F2_IDLE,
        F2_WAIT,
        F2_XFER,
        F2_DONE
    } f2_seq_state_t;

endpackage

// File: rtl/memory_f2_timebase.sv
// Digit (0..17) and minor-cycle (0..31) counters tracking the tank circulation.
// The next-position values are exported so sequencers can register gates in step with the counters.
module memory_f2_timebase
    import edsac_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] digit,
    output logic [4:0] minor,
    output logic [4:0] digit_nxt,
    output logic [4:0] minor_nxt
);

    localparam logic [4:0] LAST_DIGIT = 5'(DIGITS_PER_MINOR - 1);
    localparam logic [4:0] LAST_MINOR = 5'(MINORS_PER_TANK - 1);

    always_comb begin
        digit_nxt = digit + 5'd1;
        minor_nxt = minor;
        if (digit == LAST_DIGIT) begin
            digit_nxt = '0;
            minor_nxt = (minor == LAST_MINOR) ? '0 : minor + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
            minor <= '0;
        end else begin
            digit <= digit_nxt;
            minor <= minor_nxt;
        end
    end

endmodule

// File: rtl/memory_f2_tank_seq.sv
// Serial access sequencer for the f2 down-tank: waits for the addressed word, drives gates/f2_mib
// and deserialises f2_down_mob_t2. Define F2_LONG_WORD_EN for 35-bit long-word transfers.
module memory_f2_tank_seq
    import edsac_mem_pkg::*;
#(
    parameter int unsigned W = SHORT_W
) (
    input  logic         f2_clk,
    input  logic         f2_rst,
    input  logic         f2_cpu_req,
    input  logic         f2_cpu_wr,
    input  logic [4:0]   f2_cpu_addr,
`ifdef F2_LONG_WORD_EN
    input  logic         f2_cpu_long,
    input  logic [2*W:0] f2_cpu_wdata,
    output logic [2*W:0] f2_cpu_rdata,
`else
    input  logic [W-1:0] f2_cpu_wdata,
    output logic [W-1:0] f2_cpu_rdata,
`endif
    output logic         f2_cpu_ack,
    output logic         f2_busy,
    input  logic         f2_down_mob_t2,
    output logic         f2_mib,
    output logic         f2_down_t2_clr,
    output logic         f2_down_t2_in,
    output logic         f2_down_t2_out,
    output logic [4:0]   f2_minor,
    output logic [4:0]   f2_digit
);

`ifdef F2_LONG_WORD_EN
    localparam int unsigned DW = 2 * W + 1;
`else
    localparam int unsigned DW = W;
`endif

    f2_seq_state_t   state;
    logic [4:0]      addr_q;
    logic            wr_q;
    logic [DW-1:0]   wsh;
    logic [5:0]      idx;
    logic [5:0]      last_idx;
    logic [4:0]      digit_nxt;
    logic [4:0]      minor_nxt;

    memory_f2_timebase u_timebase (
        .clk       (f2_clk),
        .rst       (f2_rst),
        .digit     (f2_digit),
        .minor     (f2_minor),
        .digit_nxt (digit_nxt),
        .minor_nxt (minor_nxt)
    );

`ifdef F2_LONG_WORD_EN
    logic long_q;

    // A long word runs straight through the gap digit of its first minor cycle.
    always_comb begin
        last_idx = long_q ? 6'(2 * W) : 6'(W - 1);
    end
`else
    always_comb begin
        last_idx = 6'(W - 1);
    end
`endif

    always_ff @(posedge f2_clk) begin
        if (f2_rst) begin
            state          <= F2_IDLE;
            addr_q         <= '0;
            wr_q           <= 1'b0;
            wsh            <= '0;
            idx            <= '0;
            f2_cpu_rdata   <= '0;
            f2_cpu_ack     <= 1'b0;
            f2_busy        <= 1'b0;
            f2_mib         <= 1'b0;
            f2_down_t2_clr <= 1'b0;
            f2_down_t2_in  <= 1'b0;
            f2_down_t2_out <= 1'b0;
`ifdef F2_LONG_WORD_EN
            long_q         <= 1'b0;
`endif
        end else begin
            case (state)
                F2_IDLE: begin
                    if (f2_cpu_req) begin
                        state   <= F2_WAIT;
                        f2_busy <= 1'b1;
                        wr_q    <= f2_cpu_wr;
                        wsh     <= f2_cpu_wdata;
`ifdef F2_LONG_WORD_EN
                        long_q  <= f2_cpu_long;
                        addr_q  <= f2_cpu_long ? {f2_cpu_addr[4:1], 1'b0} : f2_cpu_addr;
`else
                        addr_q  <= f2_cpu_addr;
`endif
                        if (!f2_cpu_wr) begin
                            f2_cpu_rdata <= '0;
                        end
                    end
                end
                F2_WAIT: begin
                    // Gates are registered, so they are launched on the edge into (A,0).
                    if (minor_nxt == addr_q && digit_nxt == '0) begin
                        state          <= F2_XFER;
                        idx            <= '0;
                        f2_down_t2_out <= ~wr_q;
                        f2_down_t2_clr <= wr_q;
                        f2_down_t2_in  <= wr_q;
                        f2_mib         <= wr_q & wsh[0];
                        wsh            <= wsh >> 1;
                    end
                end
                F2_XFER: begin
                    if (!wr_q) begin
                        for (int unsigned i = 0; i < DW; i++) begin
                            if (idx == 6'(i)) begin
                                f2_cpu_rdata[i] <= f2_down_mob_t2;
                            end
                        end
                    end
                    if (idx == last_idx) begin
                        state          <= F2_DONE;
                        f2_down_t2_out <= 1'b0;
                        f2_down_t2_clr <= 1'b0;
                        f2_down_t2_in  <= 1'b0;
                        f2_mib         <= 1'b0;
                        f2_cpu_ack     <= 1'b1;
                    end else begin
                        idx    <= idx + 6'd1;
                        f2_mib <= wr_q & wsh[0];
                        wsh    <= wsh >> 1;
                    end
                end
                F2_DONE: begin
                    state      <= F2_IDLE;
                    f2_cpu_ack <= 1'b0;
                    f2_busy    <= 1'b0;
                end
                default: state <= F2_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_f2_tank_seq.sv
// Self-checking bench for memory_f2_tank_seq with a tank model and a position/word-level reference.
// Build with F2_LONG_WORD_EN to exercise long-word transfers.
`timescale 1ns/1ps
module tb_memory_f2_tank_seq;

    localparam int unsigned W   = 17;
    localparam int          REV = 576;
`ifdef F2_LONG_WORD_EN
    localparam int unsigned DW = 2 * W + 1;
`else
    localparam int unsigned DW = W;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          req   = 1'b0;
    logic          wr    = 1'b0;
    logic          lng   = 1'b0;
    logic          mob   = 1'b0;
    logic [4:0]    addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          ack, busy, mib, clr, tin, tout;
    logic [4:0]    minor, digit;

    int checks = 0;
    int errors = 0;

    memory_f2_tank_seq #(.W(W)) dut (
        .f2_clk         (clk),
        .f2_rst         (rst),
        .f2_cpu_req     (req),
        .f2_cpu_wr      (wr),
        .f2_cpu_addr    (addr),
`ifdef F2_LONG_WORD_EN
        .f2_cpu_long    (lng),
`endif
        .f2_cpu_wdata   (wdata),
        .f2_cpu_rdata   (rdata),
        .f2_cpu_ack     (ack),
        .f2_busy        (busy),
        .f2_down_mob_t2 (mob),
        .f2_mib         (mib),
        .f2_down_t2_clr (clr),
        .f2_down_t2_in  (tin),
        .f2_down_t2_out (tout),
        .f2_minor       (minor),
        .f2_digit       (digit)
    );

    always #5 clk = ~clk;

    // Environment tank contents and the model's idea of what each position should hold.
    bit tank   [REV];
    bit shadow [REV];
    bit known  [32];

    int            cyc     = 0;
    bit            started = 1'b0;
    bit            have    = 1'b0;
    int            t_acc, t_first, t_ack, m_len, m_base, m_a;
    bit            m_wr, m_long, m_known;
    logic [DW-1:0] m_wdata, m_rexp;
    logic [DW-1:0] rd_exp   = '0;
    bit            rd_known = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int            pos;
        int            idx;
        int            d;
        bit            e_busy, e_xf, e_ack, e_mib;
        logic [DW-1:0] tmp;
        if (started) begin
            pos = cyc % REV;
            chk("digit", 64'(digit), 64'(pos % 18));
            chk("minor", 64'(minor), 64'(pos / 18));
            e_busy = have && cyc >= t_acc && cyc <= t_ack;
            e_xf   = have && cyc >= t_first && cyc < t_ack;
            e_ack  = have && cyc == t_ack;
            idx    = cyc - t_first;
            tmp    = m_wdata >> idx;
            e_mib  = e_xf && m_wr && tmp[0];
            chk("busy", 64'(busy), 64'(e_busy));
            chk("ack", 64'(ack), 64'(e_ack));
            chk("gate_out", 64'(tout), 64'(e_xf && !m_wr));
            chk("gate_clr", 64'(clr), 64'(e_xf && m_wr));
            chk("gate_in", 64'(tin), 64'(e_xf && m_wr));
            chk("mib", 64'(mib), 64'(e_mib));
            if (e_ack && !m_wr) begin
                rd_exp   = m_rexp;
                rd_known = m_known;
            end
            if ((e_ack || !e_busy) && rd_known) chk("rdata", 64'(rdata), 64'(rd_exp));
            if (e_ack && m_wr) begin
                for (int i = 0; i < m_len; i++) begin
                    tmp = m_wdata >> i;
                    shadow[10'((m_base + i) % REV)] = tmp[0];
                end
                known[5'(m_a)] = 1'b1;
                if (m_long) known[5'(m_a + 1)] = 1'b1;
            end
            if (cyc == 0)   chk("pin_reset_rdata", 64'(rdata), 64'h0);
            if (cyc == 575) chk("pin_last_pos", 64'({minor, digit}), 64'({5'd31, 5'd17}));
            if (cyc == 576) chk("pin_wrap_pos", 64'({minor, digit}), 64'h0);
            if (clr && tin) tank[10'(pos)] = mib;
            mob = tank[10'(pos)];
            if (!rst && req && (!have || cyc > t_ack)) begin
                have    = 1'b1;
                m_wr    = wr;
                m_long  = lng;
                m_a     = lng ? (int'(addr) & ~1) : int'(addr);
                m_len   = lng ? 35 : 17;
                m_base  = m_a * 18;
                m_wdata = wdata;
                t_acc   = cyc + 1;
                d       = (m_base - (t_acc % REV) + REV) % REV;
                if (d == 0) d = REV;
                t_first = t_acc + d;
                t_ack   = t_first + m_len;
                m_rexp  = '0;
                for (int i = 0; i < m_len; i++) begin
                    if (shadow[10'((m_base + i) % REV)]) m_rexp = m_rexp | (DW'(1) << i);
                end
                m_known  = known[5'(m_a)] && (!m_long || known[5'(m_a + 1)]);
                rd_known = 1'b0;
            end
        end
        if (rst) begin
            if (have && m_wr && cyc >= t_first && cyc < t_ack) begin
                known[5'(m_a)] = 1'b0;
                if (m_long) known[5'(m_a + 1)] = 1'b0;
            end
            have     = 1'b0;
            rd_exp   = '0;
            rd_known = 1'b1;
            cyc      = 0;
            started  = 1'b1;
        end else if (started) begin
            cyc++;
        end
    end

    task automatic xfer(input bit w, input logic [4:0] a, input bit l, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd);
        int n;
        @(posedge clk); #1;
        req = 1'b1; wr = w; addr = a; lng = l; wdata = d;
        n = 0;
        while (ack !== 1'b1 && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_within_budget", 64'(ack), 64'h1);
        rd = rdata;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] rnd;
        int            n;
        bit            l;
        for (int i = 0; i < REV; i++) begin
            tank[i]   = bit'($urandom_range(0, 1));
            shadow[i] = tank[i];
        end
        for (int i = 0; i < 32; i++) known[i] = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (580) @(posedge clk);

        // Write then read back address 5.
        xfer(1'b1, 5'd5, 1'b0, DW'(17'h1A5C3), rd);
        xfer(1'b0, 5'd5, 1'b0, '0, rd);
        chk("read_addr5", 64'(rd), 64'(17'h1A5C3));

        // Request sampled while counters read (3,3): acceptance at (3,4), ack a revolution later.
        n = 0;
        while (!(minor == 5'd3 && digit == 5'd3) && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        req = 1'b1; wr = 1'b0; addr = 5'd3; lng = 1'b0;
        n = 0;
        while (ack !== 1'b1 && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency_from_sample", 64'(n), 64'd590);
        @(posedge clk); #1;
        req = 1'b0;

        // Held request: address changes while busy are ignored; re-accepted in IDLE after ack.
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b0; addr = 5'd10; lng = 1'b0;
        n = 0;
        while (ack !== 1'b1 && n < 700) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) addr = 5'd20;
        end
        chk("held_first_ack", 64'(ack), 64'h1);
        @(posedge clk); #1;
        chk("held_idle_gap_busy", 64'(busy), 64'h0);
        @(posedge clk); #1;
        req = 1'b0;
        chk("held_reaccepted", 64'(busy), 64'h1);
        n = 0;
        while (ack !== 1'b1 && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_second_ack", 64'(ack), 64'h1);
        @(posedge clk); #1;

        // Reset in the middle of a write at digit 8.
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b1; addr = 5'd9; lng = 1'b0; wdata = DW'($urandom);
        n = 0;
        while (!(tin === 1'b1 && digit == 5'd8) && n < 700) begin
            @(posedge clk); #1;
            n++;
            if (busy === 1'b1) req = 1'b0;
        end
        chk("midwrite_reached", 64'(tin), 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_gate_in", 64'(tin), 64'h0);
        chk("rst_gate_clr", 64'(clr), 64'h0);
        chk("rst_counters", 64'({minor, digit}), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        repeat (600) @(posedge clk);
        #1;

        // Randomised traffic against the reference model.
        for (int k = 0; k < 24; k++) begin
`ifdef F2_LONG_WORD_EN
            l = bit'($urandom_range(0, 1));
`else
            l = 1'b0;
`endif
            rnd = DW'({$urandom, $urandom});
            xfer(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), l, rnd, rd);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

`ifdef F2_LONG_WORD_EN
        // Long write to an odd address lands on the even pair (6,7).
        xfer(1'b1, 5'd7, 1'b1, 35'h5_A5A5_A5A5, rd);
        xfer(1'b0, 5'd6, 1'b1, '0, rd);
        chk("long_read_addr6", 64'(rd), 64'(35'h5_A5A5_A5A5));
`endif

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
